// File: rtl/light_hash_des.sv
// Byte-serial 32-bit hash: DES-style Feistel compression, then 0x80 padding and a 64-bit length.
// Define LIGHT_HASH_DES_ROUNDS8_EN for 8 Feistel rounds per absorb (default 4).
module light_hash_des (
  input  logic        clk,
  input  logic        rst,
  input  logic        M_valid,
  input  logic [7:0]  M,
  input  logic [63:0] input_length,
  output logic        hash_ready,
  output logic [31:0] digest
);

`ifdef LIGHT_HASH_DES_ROUNDS8_EN
  localparam int unsigned NR = 8;
`else
  localparam int unsigned NR = 4;
`endif

  localparam logic [31:0] IV = 32'h6A09E667;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ABSORB,
    S_PAD,
    S_LEN,
    S_DONE
  } state_t;

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
      4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
      4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
      4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
    endcase
    return y;
  endfunction

  function automatic logic [31:0] absorb(input logic [31:0] h, input logic [7:0] b);
    logic [15:0] l, r, k, s, t;
    l = h[31:16];
    r = h[15:0];
    for (int unsigned i = 0; i < NR; i++) begin
      k = ({b, b} ^ 16'hA55A) + 16'(i);
      t = r ^ k;
      s = {sbox4(t[15:12]), sbox4(t[11:8]), sbox4(t[7:4]), sbox4(t[3:0])};
      t = l ^ {s[12:0], s[15:13]};
      l = r;
      r = t;
    end
    return {l, r} ^ h;
  endfunction

  state_t      state_q, state_d;
  logic [31:0] h_q, h_d;
  logic [63:0] cnt_q, cnt_d;
  logic [2:0]  j_q, j_d;
  logic        ready_q, ready_d;
  logic [31:0] digest_q, digest_d;

  logic [7:0]  byte_sel;
  logic [31:0] h_abs;
  logic [63:0] cnt_inc;

  // One shared compression datapath; the FSM state picks which byte feeds it.
  always_comb begin
    byte_sel = M;
    case (state_q)
      S_PAD:   byte_sel = 8'h80;
      S_LEN:   byte_sel = input_length[{j_q, 3'b000} +: 8];
      default: byte_sel = M;
    endcase
  end

  assign h_abs   = absorb(h_q, byte_sel);
  assign cnt_inc = cnt_q + 64'd1;

  always_comb begin
    state_d  = state_q;
    h_d      = h_q;
    cnt_d    = cnt_q;
    j_d      = j_q;
    ready_d  = ready_q;
    digest_d = digest_q;
    case (state_q)
      S_IDLE: begin
        if (input_length == '0) begin
          state_d = S_PAD;
        end else if (M_valid) begin
          h_d     = h_abs;
          cnt_d   = 64'd1;
          state_d = (input_length == 64'd1) ? S_PAD : S_ABSORB;
        end else begin
          state_d = S_ABSORB;
        end
      end
      S_ABSORB: begin
        if (M_valid) begin
          h_d   = h_abs;
          cnt_d = cnt_inc;
          if (cnt_inc == input_length) state_d = S_PAD;
        end
      end
      S_PAD: begin
        h_d     = h_abs;
        j_d     = '0;
        state_d = S_LEN;
      end
      S_LEN: begin
        h_d = h_abs;
        if (j_q == 3'd7) begin
          state_d  = S_DONE;
          ready_d  = 1'b1;
          digest_d = h_abs;
        end else begin
          j_d = j_q + 3'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      h_q      <= IV;
      cnt_q    <= '0;
      j_q      <= '0;
      ready_q  <= 1'b0;
      digest_q <= '0;
    end else begin
      state_q  <= state_d;
      h_q      <= h_d;
      cnt_q    <= cnt_d;
      j_q      <= j_d;
      ready_q  <= ready_d;
      digest_q <= digest_d;
    end
  end

  assign hash_ready = ready_q;
  assign digest     = digest_q;

endmodule

// File: tb/tb_light_hash_des.sv
// Self-checking bench for light_hash_des: vector table, corner sequences and random messages vs a reference model.
module tb_light_hash_des;

`ifdef LIGHT_HASH_DES_ROUNDS8_EN
  localparam int unsigned NR = 8;
`else
  localparam int unsigned NR = 4;
`endif

  localparam int unsigned SBOX [16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        M_valid = 1'b0;
  logic [7:0]  M = '0;
  logic [63:0] input_length = '0;
  logic        hash_ready;
  logic [31:0] digest;

  int checks = 0;
  int errors = 0;

  light_hash_des dut (
    .clk          (clk),
    .rst          (rst),
    .M_valid      (M_valid),
    .M            (M),
    .input_length (input_length),
    .hash_ready   (hash_ready),
    .digest       (digest)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_absorb(input logic [31:0] h, input logic [7:0] b);
    int unsigned l, r, k, x, s, f, nl;
    l = int'(h) >> 16;
    r = int'(h) & 32'hFFFF;
    for (int unsigned i = 0; i < NR; i++) begin
      k = (((int'(b) * 257) ^ 32'hA55A) + i) % 65536;
      x = r ^ k;
      s = 0;
      for (int unsigned n = 0; n < 4; n++)
        s = s + (SBOX[(x >> (4 * n)) % 16] << (4 * n));
      f = ((s * 8) + (s >> 13)) % 65536;
      nl = r;
      r = l ^ f;
      l = nl;
    end
    return 32'(l * 65536 + r) ^ h;
  endfunction

  function automatic logic [31:0] ref_digest(input logic [7:0] msg[$], input logic [63:0] len);
    logic [31:0] h;
    h = 32'h6A09E667;
    foreach (msg[i]) h = ref_absorb(h, msg[i]);
    h = ref_absorb(h, 8'h80);
    for (int j = 0; j < 8; j++) h = ref_absorb(h, 8'(len >> (8 * j)));
    return h;
  endfunction

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_ne(input string name, input logic [63:0] act, input logic [63:0] other);
    checks++;
    if (act === other) begin
      errors++;
      $display("FAIL %s: got %h expected a value different from %h", name, act, other);
    end
  endtask

  task automatic apply_reset(input logic [63:0] len);
    @(negedge clk);
    rst = 1'b1;
    M_valid = 1'b0;
    input_length = len;
    #1;
    check_eq("reset_ready", 64'(hash_ready), 64'd0);
    check_eq("reset_digest", 64'(digest), 64'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) begin
      @(posedge clk);
      @(negedge clk);
    end
    M_valid = 1'b1;
    M = b;
    @(posedge clk);
    @(negedge clk);
    M_valid = 1'b0;
    M = 8'($urandom);
  endtask

  // Resets, streams the message, then measures edges from the last byte until hash_ready.
  task automatic run_msg(input logic [63:0] len, input logic [7:0] msg[$], input int gap,
                         output logic [31:0] dig, output int lat);
    apply_reset(len);
    foreach (msg[i]) send_byte(msg[i], gap);
    lat = 0;
    while (!hash_ready && lat < 30) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 8) begin
        check_eq("early_ready", 64'(hash_ready), 64'd0);
        check_eq("early_digest", 64'(digest), 64'd0);
      end
    end
    if (!hash_ready) begin
      errors++;
      $display("FAIL timeout: hash_ready still %b after %0d edges, required 1", hash_ready, lat);
    end
    dig = digest;
  endtask

  typedef struct {
    logic [63:0] len;
    logic [63:0] data;
    int          gap;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [7:0]  q[$];
    logic [31:0] dig, d_empty, d_a, d_abc, d_clean;
    logic [63:0] d64;
    int          lat, len, gap;

    vecs[0] = '{len: 64'd0, data: 64'h0,                 gap: 0, exp: '0};
    vecs[1] = '{len: 64'd1, data: 64'h41,                gap: 0, exp: '0};
    vecs[2] = '{len: 64'd3, data: 64'h636261,            gap: 0, exp: '0};
    vecs[3] = '{len: 64'd3, data: 64'h636261,            gap: 2, exp: '0};
    vecs[4] = '{len: 64'd8, data: 64'h0123456789ABCDEF,  gap: 1, exp: '0};
    vecs[5] = '{len: 64'd1, data: 64'h41,                gap: 3, exp: '0};
    foreach (vecs[v]) begin
      q.delete();
      d64 = vecs[v].data;
      for (int i = 0; i < int'(vecs[v].len); i++) q.push_back(d64[8*i +: 8]);
      vecs[v].exp = ref_digest(q, vecs[v].len);
    end

    for (int v = 0; v < 6; v++) begin
      q.delete();
      d64 = vecs[v].data;
      for (int i = 0; i < int'(vecs[v].len); i++) q.push_back(d64[8*i +: 8]);
      run_msg(vecs[v].len, q, vecs[v].gap, dig, lat);
      check_eq($sformatf("vec%0d_latency", v), 64'(lat), (vecs[v].len == 0) ? 64'd10 : 64'd9);
      check_eq($sformatf("vec%0d_digest", v), 64'(dig), 64'(vecs[v].exp));
      if (v == 0) d_empty = dig;
      if (v == 1) d_a = dig;
      if (v == 2) d_abc = dig;
      if (v == 3) check_eq("abc_gap_same", 64'(dig), 64'(d_abc));
    end
    check_ne("empty_nonzero", 64'(d_empty), 64'd0);
    check_ne("a_vs_empty", 64'(d_a), 64'(d_empty));

    // Extra byte after completion must be ignored.
    q = '{8'h61, 8'h62, 8'h63};
    run_msg(64'd3, q, 0, dig, lat);
    send_byte(8'h64, 0);
    check_eq("extra_digest", 64'(digest), 64'(d_abc));
    check_eq("extra_ready", 64'(hash_ready), 64'd1);
    repeat (3) @(negedge clk);
    check_eq("done_hold", 64'(digest), 64'(d_abc));

    // Asynchronous reset while done clears outputs without waiting for an edge.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst_ready", 64'(hash_ready), 64'd0);
    check_eq("async_rst_digest", 64'(digest), 64'd0);

    // Abort mid-message, then a clean rerun.
    q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    apply_reset(64'd5);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    #2 rst = 1'b1;
    #1;
    check_eq("mid_rst_ready", 64'(hash_ready), 64'd0);
    check_eq("mid_rst_digest", 64'(digest), 64'd0);
    run_msg(64'd5, q, 0, d_clean, lat);
    check_eq("rerun_digest", 64'(d_clean), 64'(ref_digest(q, 64'd5)));
    check_eq("rerun_latency", 64'(lat), 64'd9);

    // Long message exercises upper counter and length-field bytes.
    q.delete();
    for (int i = 0; i < 258; i++) q.push_back(8'($urandom));
    run_msg(64'd258, q, 0, dig, lat);
    check_eq("long_digest", 64'(dig), 64'(ref_digest(q, 64'd258)));
    check_eq("long_latency", 64'(lat), 64'd9);

    for (int t = 0; t < 20; t++) begin
      len = int'($urandom_range(0, 12));
      gap = int'($urandom_range(0, 2));
      q.delete();
      for (int i = 0; i < len; i++) q.push_back(8'($urandom));
      run_msg(64'(len), q, gap, dig, lat);
      check_eq($sformatf("rand%0d_digest", t), 64'(dig), 64'(ref_digest(q, 64'(len))));
      check_eq($sformatf("rand%0d_latency", t), 64'(lat), (len == 0) ? 64'd10 : 64'd9);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
